restoring_divider: RTL and testbench

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/restoring_divider.sv | 171 +++++++++++++++++
 tb/tb_restoring_divider.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - signed restoring divider, 2N-bit dividend by N-bit divisor
//
// Parameters:
//   N          divisor / quotient / remainder width; the dividend is 2N bits
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   start      begin a division; sampled only in IDLE or DONE
//   dividend   signed 2N-bit dividend, captured when start is accepted
//   divisor    signed N-bit divisor, captured when start is accepted
//   quotient   signed N-bit quotient (low N bits of the true quotient on overflow)
//   remainder  signed N-bit remainder, sign follows the dividend
//   busy       high while the division is in CALC or FIX
//   done       one-cycle pulse in DONE; results are valid from here on
//   dbz        divide-by-zero flag, valid with done
//   ovf        quotient does not fit in N signed bits, valid with done

module restoring_divider #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           busy,
    output logic           done,
    output logic           dbz,
    output logic           ovf
);

    localparam int CW = $clog2(2 * N);
    localparam logic [CW-1:0]  LAST_ITER = CW'(2 * N - 1);
    localparam logic [2*N-1:0] QMAX_POS  = (2 * N)'((2 ** (N - 1)) - 1);
    localparam logic [2*N-1:0] QMAX_NEG  = (2 * N)'(2 ** (N - 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]  count;
    logic [N-1:0]   rem;        // partial remainder, always below |divisor|
    logic [2*N-1:0] dq;         // dividend bits shift out the top, quotient bits in the bottom
    logic [N-1:0]   dvs_mag;
    logic           sign_a;
    logic           sign_b;
    logic           zero_div;

    logic           accept;
    logic [2*N-1:0] dividend_mag;
    logic [N-1:0]   divisor_mag;
    logic [N:0]     shifted;
    logic           fits;
    logic [N-1:0]   diff;
    logic           neg_q;
    logic [N-1:0]   q_signed;
    logic [N-1:0]   r_signed;
    logic           ovf_calc;

    assign accept = start && ((state == IDLE) || (state == DONE));

    // Two's-complement magnitudes; the most negative value maps to its
    // unsigned magnitude (e.g. 0x8000 stays 0x8000 = 32768).
    assign dividend_mag = dividend[2*N-1] ? ((~dividend) + (2 * N)'(1)) : dividend;
    assign divisor_mag  = divisor[N-1]    ? ((~divisor) + N'(1))        : divisor;

    // One restoring step on the (N+1)-bit shifted partial remainder. When the
    // trial subtraction succeeds the difference is below |divisor|, so its low
    // N bits are exact.
    assign shifted = {rem, dq[2*N-1]};
    assign fits    = (shifted >= {1'b0, dvs_mag});
    assign diff    = shifted[N-1:0] - dvs_mag;

    // Sign fix-up: truncating division, remainder takes the dividend sign.
    assign neg_q    = sign_a ^ sign_b;
    assign q_signed = neg_q  ? ((~dq[N-1:0]) + N'(1)) : dq[N-1:0];
    assign r_signed = sign_a ? ((~rem) + N'(1))       : rem;
    assign ovf_calc = neg_q  ? (dq > QMAX_NEG) : (dq > QMAX_POS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (count == LAST_ITER) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? CALC : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            rem       <= '0;
            dq        <= '0;
            dvs_mag   <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            zero_div  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else if (accept) begin
            count    <= '0;
            rem      <= '0;
            dq       <= dividend_mag;
            dvs_mag  <= divisor_mag;
            sign_a   <= dividend[2*N-1];
            sign_b   <= divisor[N-1];
            zero_div <= (divisor == '0);
        end else if (state == CALC) begin
            count <= count + CW'(1);
            if (fits) begin
                rem <= diff;
                dq  <= {dq[2*N-2:0], 1'b1};
            end else begin
                rem <= shifted[N-1:0];
                dq  <= {dq[2*N-2:0], 1'b0};
            end
        end else if (state == FIX) begin
            if (zero_div) begin
                quotient  <= '0;
                remainder <= '0;
                dbz       <= 1'b1;
                ovf       <= 1'b0;
            end else begin
                quotient  <= q_signed;
                remainder <= r_signed;
                dbz       <= 1'b0;
                ovf       <= ovf_calc;
            end
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// tb/tb_restoring_divider.sv - scoreboard bench for restoring_divider (N=8)

module tb_restoring_divider;

    localparam int N = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic [N-1:0]   quotient;
    logic [N-1:0]   remainder;
    logic           busy;
    logic           done;
    logic           dbz;
    logic           ovf;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;

    int tests_run = 0;
    int tests_failed = 0;

    restoring_divider #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: truncating signed division on wide integers.
    function automatic exp_t model(input logic signed [2*N-1:0] a_in,
                                   input logic signed [N-1:0] b_in);
        exp_t   e;
        longint a;
        longint b;
        longint qt;
        longint rt;
        a = a_in;
        b = b_in;
        if (b == 0) begin
            e.q   = '0;
            e.r   = '0;
            e.dbz = 1'b1;
            e.ovf = 1'b0;
        end else begin
            qt    = a / b;
            rt    = a % b;
            e.q   = qt[N-1:0];
            e.r   = rt[N-1:0];
            e.dbz = 1'b0;
            e.ovf = (qt > 127) || (qt < -128);
        end
        return e;
    endfunction

    // Called just after a falling edge; the next rising edge accepts.
    task automatic launch(input logic signed [2*N-1:0] a, input logic signed [N-1:0] b,
                          input bit expect_result);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        if (expect_result) sb.push_back(model(a, b));
    endtask

    // Counts rising edges from the accepting edge until done is seen.
    // A nonzero glitch_at pulses start with other operands during CALC.
    task automatic wait_done(input string tag, input int glitch_at);
        int cyc;
        int busy_cnt;
        cyc      = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (busy) busy_cnt++;
            if (cyc == glitch_at) begin
                start    = 1'b1;
                dividend = 16'sd9;
                divisor  = 8'sd3;
            end
        end while (!done && cyc < 100);
        check({tag, "_latency"}, cyc, 18);
        check({tag, "_busy_cycles"}, busy_cnt, 17);
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                last_exp = sb.pop_front();
                check("quotient",  quotient,  last_exp.q);
                check("remainder", remainder, last_exp.r);
                check("dbz",       dbz,       last_exp.dbz);
                check("ovf",       ovf,       last_exp.ovf);
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_quotient"},  quotient,  0);
        check({tag, "_remainder"}, remainder, 0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
        check({tag, "_dbz"},       dbz,       0);
        check({tag, "_ovf"},       ovf,       0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #3;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        launch(16'sd100, 8'sd7, 1'b1);    wait_done("d100_7", 0);
        launch(-16'sd100, 8'sd7, 1'b1);   wait_done("dm100_7", 0);
        launch(16'sd100, -8'sd7, 1'b1);   wait_done("d100_m7", 0);
        launch(-16'sd100, -8'sd7, 1'b1);  wait_done("dm100_m7", 0);
        launch(16'sd16384, -8'sd128, 1'b1); wait_done("d16384_m128", 0);
        launch(16'sd16384, 8'sd1, 1'b1);  wait_done("d16384_1", 0);
        launch(16'h8000, -8'sd1, 1'b1);   wait_done("dmin_m1", 0);
        launch(16'sd1234, 8'sd0, 1'b1);   wait_done("d1234_0", 0);

        // done is a single pulse and results hold through IDLE.
        @(negedge clk);
        check("done_pulse_width", done, 0);
        repeat (3) @(negedge clk);
        check("hold_quotient", quotient, last_exp.q);
        check("hold_dbz", dbz, last_exp.dbz);

        // start during CALC with other operands must be ignored.
        launch(16'sd77, 8'sd5, 1'b1);     wait_done("glitch", 5);

        // Back-to-back: start held high in DONE.
        @(negedge clk);
        launch(16'sd100, 8'sd7, 1'b1);    wait_done("b2b_first", 0);
        launch(16'sd50, 8'sd5, 1'b1);     wait_done("b2b_second", 0);
        @(negedge clk);

        // Asynchronous reset mid-division: no done, outputs cleared at once.
        launch(16'sd100, 8'sd7, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("mid_reset_queue", sb.size(), 0);
        launch(16'sd100, 8'sd7, 1'b1);    wait_done("after_reset", 0);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            launch(16'($urandom), 8'($urandom), 1'b1);
            wait_done("random", 0);
        end

        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
